calc_sequencer: RTL and testbench

Program sequencer for the limited-function calculator datapath. On a start request it fetches a run of instruction words from the instruction memory, decodes each funct field into the datapath's sign and store-previous controls, and issues them one per two cycles. It gates the accumulator write-enable and reports the final accumulator value with a done pulse. It sits between the host/testbench and the calculator datapath and replaces the free-running, always-writing accumulator arrangement.

---
 rtl/calc_seq_pkg.sv | 34 +++
 rtl/calc_seq_decode.sv | 30 +++
 rtl/calc_sequencer.sv | 153 +++++++++++++++
 tb/tb_calc_sequencer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_seq_pkg.sv
// Shared definitions for the calculator program sequencer: FSM states, funct codes
// and instruction field positions. The WAIT state exists only with CALC_SEQ_STEP_EN.
package calc_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FETCH = 3'd2,
        ST_ISSUE = 3'd3,
        ST_DONE  = 3'd4
`ifdef CALC_SEQ_STEP_EN
        ,
        ST_WAIT  = 3'd5
`endif
    } state_t;

    localparam logic [2:0] FUNCT_ADD  = 3'b000;
    localparam logic [2:0] FUNCT_SUB  = 3'b001;
    localparam logic [2:0] FUNCT_ACC  = 3'b010;
    localparam logic [2:0] FUNCT_RSUB = 3'b011;
    localparam logic [2:0] FUNCT_HALT = 3'b111;

    localparam int FUNCT_MSB = 30;
    localparam int FUNCT_LSB = 28;
    localparam int IMMA_MSB  = 27;
    localparam int IMMA_LSB  = 14;
    localparam int IMMB_MSB  = 13;
    localparam int IMMB_LSB  = 0;

    function automatic logic [2:0] get_funct(input logic [31:0] word);
        return word[FUNCT_MSB:FUNCT_LSB];
    endfunction

endpackage

// File: rtl/calc_seq_decode.sv
// Combinational funct decoder: maps a funct code onto the datapath controls
// plus the write / halt / illegal classification used by the sequencer.
module calc_seq_decode
    import calc_seq_pkg::*;
(
    input  logic [2:0] i_funct,
    output logic       o_sign,
    output logic       o_store_prev,
    output logic       o_write,
    output logic       o_halt,
    output logic       o_illegal
);

    always_comb begin
        o_sign       = 1'b0;
        o_store_prev = 1'b0;
        o_write      = 1'b0;
        o_halt       = 1'b0;
        o_illegal    = 1'b0;
        case (i_funct)
            FUNCT_ADD:  begin o_store_prev = 1'b1; o_write = 1'b1; end
            FUNCT_SUB:  begin o_sign = 1'b1; o_store_prev = 1'b1; o_write = 1'b1; end
            FUNCT_ACC:  begin o_write = 1'b1; end
            FUNCT_RSUB: begin o_sign = 1'b1; o_write = 1'b1; end
            FUNCT_HALT: begin o_halt = 1'b1; end
            default:    begin o_illegal = 1'b1; end
        endcase
    end

endmodule

// File: rtl/calc_sequencer.sv
// Program sequencer for the calculator datapath: fetches, decodes and issues a run
// of instructions, gating the accumulator write. Optional single-step: CALC_SEQ_STEP_EN.
module calc_sequencer
    import calc_seq_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 9
) (
`ifdef CALC_SEQ_STEP_EN
    input  logic              step_mode,
    input  logic              step,
`endif
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [31:0]       result,
    output logic [LEN_W-1:0]  issued,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_rd,
    input  logic [31:0]       imem_data,
    output logic [31:0]       dp_instruction,
    output logic              dp_sign,
    output logic              dp_store_prev,
    output logic              dp_accum_we,
    output logic              dp_accum_clr,
    input  logic [31:0]       dp_result
);

    state_t            r_state;
    state_t            w_state_next;
    state_t            w_fetch_next;
    logic [ADDR_W-1:0] r_pc;
    logic [LEN_W-1:0]  r_remaining;
    logic [LEN_W-1:0]  r_issued;
    logic              r_error;
    logic [31:0]       r_result;
    logic [31:0]       r_dp_instruction;
    logic              r_dp_sign;
    logic              r_dp_store_prev;

    logic w_sign;
    logic w_store_prev;
    logic w_write;
    logic w_halt;
    logic w_illegal;

    calc_seq_decode u_decode (
        .i_funct      (get_funct(imem_data)),
        .o_sign       (w_sign),
        .o_store_prev (w_store_prev),
        .o_write      (w_write),
        .o_halt       (w_halt),
        .o_illegal    (w_illegal)
    );

`ifdef CALC_SEQ_STEP_EN
    assign w_fetch_next = step_mode ? ST_WAIT : ST_FETCH;
`else
    assign w_fetch_next = ST_FETCH;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_next = ST_CLEAR;
            ST_CLEAR: w_state_next = (r_remaining == '0) ? ST_DONE : w_fetch_next;
            ST_FETCH: w_state_next = ST_ISSUE;
            ST_ISSUE: w_state_next = (w_write && r_remaining != LEN_W'(1)) ? w_fetch_next : ST_DONE;
            ST_DONE:  w_state_next = ST_IDLE;
`ifdef CALC_SEQ_STEP_EN
            ST_WAIT:  if (step) w_state_next = ST_FETCH;
`endif
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc             <= '0;
            r_remaining      <= '0;
            r_issued         <= '0;
            r_error          <= 1'b0;
            r_result         <= '0;
            r_dp_instruction <= '0;
            r_dp_sign        <= 1'b0;
            r_dp_store_prev  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_pc        <= start_addr;
                        r_remaining <= length;
                        r_issued    <= '0;
                        r_error     <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    r_dp_instruction <= imem_data;
                    r_dp_sign        <= w_sign;
                    r_dp_store_prev  <= w_store_prev;
                    if (w_write) begin
                        r_pc        <= r_pc + ADDR_W'(1);
                        r_remaining <= r_remaining - LEN_W'(1);
                        r_issued    <= r_issued + LEN_W'(1);
                    end
                    if (w_illegal) r_error <= 1'b1;
                end
                ST_DONE: r_result <= dp_result;
                default: ;
            endcase
        end
    end

    // The fetched word only arrives during ISSUE, so the controls bypass the hold
    // registers in that cycle and the write lands on the edge that ends ISSUE.
    always_comb begin
        busy           = (r_state != ST_IDLE);
        done           = (r_state == ST_DONE);
        imem_rd        = (r_state == ST_FETCH);
        dp_accum_clr   = (r_state == ST_CLEAR);
        dp_accum_we    = (r_state == ST_ISSUE) && w_write;
        dp_instruction = r_dp_instruction;
        dp_sign        = r_dp_sign;
        dp_store_prev  = r_dp_store_prev;
        if (r_state == ST_ISSUE) begin
            dp_instruction = imem_data;
            dp_sign        = w_sign;
            dp_store_prev  = w_store_prev;
        end
    end

    assign imem_addr = r_pc;
    assign error     = r_error;
    assign result    = r_result;
    assign issued    = r_issued;

    logic w_unused;
    assign w_unused = w_halt;

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: behavioural instruction memory and accumulator datapath,
// directed runs from the test plan plus randomized programs against a program-level model.
module tb_calc_sequencer;
    import calc_seq_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  start_addr = '0;
    logic [8:0]  length = '0;
    logic        busy, done, error;
    logic [31:0] result;
    logic [8:0]  issued;
    logic [7:0]  imem_addr;
    logic        imem_rd;
    logic [31:0] imem_data = '0;
    logic [31:0] dp_instruction;
    logic        dp_sign, dp_store_prev, dp_accum_we, dp_accum_clr;
    logic [31:0] dp_result;
`ifdef CALC_SEQ_STEP_EN
    logic        step_mode = 1'b0;
    logic        step = 1'b0;
`endif

    always #5 clk = ~clk;

    calc_sequencer #(.ADDR_W(8), .LEN_W(9)) dut (
`ifdef CALC_SEQ_STEP_EN
        .step_mode      (step_mode),
        .step           (step),
`endif
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .start_addr     (start_addr),
        .length         (length),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .result         (result),
        .issued         (issued),
        .imem_addr      (imem_addr),
        .imem_rd        (imem_rd),
        .imem_data      (imem_data),
        .dp_instruction (dp_instruction),
        .dp_sign        (dp_sign),
        .dp_store_prev  (dp_store_prev),
        .dp_accum_we    (dp_accum_we),
        .dp_accum_clr   (dp_accum_clr),
        .dp_result      (dp_result)
    );

    // Synchronous-read instruction memory
    logic [31:0] mem [0:255];
    always @(posedge clk) if (imem_rd) imem_data <= mem[imem_addr];

    // Accumulator datapath: A = immA, B = immB or acc, sign selects subtract
    logic [31:0] acc = '0;
    logic [31:0] dp_a, dp_b;
    always @(posedge clk) begin
        dp_a = {18'd0, dp_instruction[27:14]};
        dp_b = dp_store_prev ? {18'd0, dp_instruction[13:0]} : acc;
        if (dp_accum_clr)     acc <= '0;
        else if (dp_accum_we) acc <= dp_sign ? dp_a - dp_b : dp_a + dp_b;
    end
    assign dp_result = acc;

    int checks = 0;
    int failures = 0;
    logic [31:0] last_result;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ins(input logic [2:0] f, input logic [13:0] a, input logic [13:0] b);
        return {1'b0, f, a, b};
    endfunction

    // Program-level model: walk the instruction list with plain arithmetic
    task automatic model_run(input logic [7:0] sa, input logic [8:0] len,
                             output logic [31:0] m_acc, output int m_issued,
                             output bit m_err, output int m_done_cyc);
        logic [31:0] w, a, b;
        bit stopped;
        m_acc = 0; m_issued = 0; m_err = 0; stopped = 0;
        for (int k = 0; k < int'(len) && !stopped; k++) begin
            w = mem[8'((int'(sa) + k) % 256)];
            a = 32'(w[27:14]);
            b = 32'(w[13:0]);
            case (w[30:28])
                3'd0: m_acc = a + b;
                3'd1: m_acc = a - b;
                3'd2: m_acc = a + m_acc;
                3'd3: m_acc = a - m_acc;
                3'd7: stopped = 1;
                default: begin m_err = 1; stopped = 1; end
            endcase
            if (!stopped) m_issued++;
        end
        m_done_cyc = 2 + 2 * m_issued + (stopped ? 2 : 0);
    endtask

    task automatic do_run(input string name, input logic [7:0] sa, input logic [8:0] len, input bit spurious);
        logic [31:0] m_acc;
        int m_issued, m_done_cyc, cyc, done_cyc, we_cnt;
        bit m_err, busy_ok, err_c1, err_done;
        model_run(sa, len, m_acc, m_issued, m_err, m_done_cyc);
        @(negedge clk);
        start = 1'b1; start_addr = sa; length = len;
        @(posedge clk); #1 start = 1'b0;
        cyc = 0; done_cyc = -1; we_cnt = 0; busy_ok = 1; err_c1 = 0; err_done = 0;
        while (done_cyc < 0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (dp_accum_we) we_cnt++;
            if (!busy) busy_ok = 0;
            if (cyc == 1) err_c1 = error;
            if (done) begin done_cyc = cyc; err_done = error; end
            if (spurious && cyc == 2) begin
                start = 1'b1; start_addr = ~sa; length = 9'd5;
            end
        end
        start = 1'b0;
        @(negedge clk);
        last_result = result;
        $display("run %s addr=%0d len=%0d done_cyc=%0d result=%0d issued=%0d error=%0b",
                 name, sa, len, done_cyc, result, issued, error);
        check_eq({name, ".done_cyc"}, 32'(done_cyc), 32'(m_done_cyc));
        check_eq({name, ".result"}, result, m_acc);
        check_eq({name, ".issued"}, 32'(issued), 32'(m_issued));
        check_eq({name, ".we_pulses"}, 32'(we_cnt), 32'(m_issued));
        check_eq({name, ".err_clear"}, 32'(err_c1), 32'd0);
        check_eq({name, ".err_done"}, 32'(err_done), 32'(m_err));
        check_eq({name, ".err_sticky"}, 32'(error), 32'(m_err));
        check_eq({name, ".busy_run"}, 32'(busy_ok), 32'd1);
        check_eq({name, ".idle"}, {30'd0, busy, done}, 32'd0);
    endtask

    function automatic logic [31:0] out_vec();
        return {busy, done, error, imem_rd, dp_sign, dp_store_prev, dp_accum_we, dp_accum_clr};
    endfunction

    task automatic check_reset_outputs(input string name);
        check_eq({name, ".ctl"}, out_vec(), 32'd0);
        check_eq({name, ".result"}, result, 32'd0);
        check_eq({name, ".cnt_addr"}, {15'd0, issued, imem_addr}, 32'd0);
        check_eq({name, ".dp_instr"}, dp_instruction, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = ins(3'd7, 14'd0, 14'd0);
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        mem[0] = ins(FUNCT_ADD, 14'd5, 14'd3);
        do_run("tp_add", 8'd0, 9'd1, 0);
        check_eq("tp_add.const", last_result, 32'd8);

        mem[0] = ins(FUNCT_ADD, 14'd10, 14'd4);
        mem[1] = ins(FUNCT_ACC, 14'd1, 14'd0);
        mem[2] = ins(FUNCT_RSUB, 14'd20, 14'd0);
        do_run("tp_chain", 8'd0, 9'd3, 0);
        check_eq("tp_chain.const", last_result, 32'd5);

        mem[1] = ins(FUNCT_HALT, 14'd7, 14'd7);
        do_run("tp_halt", 8'd0, 9'd4, 0);

        mem[0] = ins(3'b101, 14'd9, 14'd9);
        do_run("tp_illegal", 8'd0, 9'd2, 0);
        mem[0] = ins(FUNCT_SUB, 14'd100, 14'd30);
        do_run("tp_recover", 8'd0, 9'd1, 1);

        do_run("tp_len0", 8'd17, 9'd0, 1);

        // Wrap from 255 to 0, then reset during the second FETCH
        mem[255] = ins(FUNCT_ADD, 14'd1, 14'd2);
        mem[0]   = ins(FUNCT_ADD, 14'd3, 14'd4);
        @(negedge clk);
        start = 1'b1; start_addr = 8'd255; length = 9'd2;
        @(posedge clk); #1 start = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("wrap.fetch0", {23'd0, imem_rd, imem_addr}, {23'd0, 1'b1, 8'd255});
        repeat (2) @(negedge clk);
        check_eq("wrap.fetch1", {23'd0, imem_rd, imem_addr}, {23'd0, 1'b1, 8'd0});
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midrun_reset");
        @(posedge clk); #1 reset_n = 1'b1;

`ifdef CALC_SEQ_STEP_EN
        step_mode = 1'b1;
        mem[0] = ins(FUNCT_ADD, 14'd2, 14'd2);
        mem[1] = ins(FUNCT_ACC, 14'd3, 14'd0);
        @(negedge clk);
        start = 1'b1; start_addr = 8'd0; length = 9'd2;
        @(posedge clk); #1 start = 1'b0;
        repeat (6) @(negedge clk);
        check_eq("step.hold", {29'd0, busy, done, imem_rd}, {29'd0, 3'b100});
        check_eq("step.hold_cnt", 32'(issued), 32'd0);
        step = 1'b1; @(negedge clk); step = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("step.one", 32'(issued), 32'd1);
        check_eq("step.one_busy", {30'd0, busy, done}, 32'd2);
        step = 1'b1; @(negedge clk); step = 1'b0;
        for (int i = 0; i < 10 && !done; i++) @(negedge clk);
        check_eq("step.done", {30'd0, done, 1'b0}, 32'd2);
        check_eq("step.two", 32'(issued), 32'd2);
        @(negedge clk);
        check_eq("step.result", result, 32'd7);
        step_mode = 1'b0;
`endif

        // Randomized programs, with a spurious start pulse mid-run
        for (int r = 0; r < 40; r++) begin
            if (r % 8 == 0) begin
                for (int i = 0; i < 256; i++) begin
                    int sel;
                    logic [2:0] f;
                    sel = int'($urandom_range(0, 15));
                    if (sel < 12)      f = 3'(sel % 4);
                    else if (sel < 14) f = FUNCT_HALT;
                    else               f = 3'(4 + $urandom_range(0, 2));
                    mem[i] = {1'($urandom_range(0, 1)), f, 14'($urandom), 14'($urandom)};
                end
            end
            do_run($sformatf("rnd%0d", r), 8'($urandom), 9'($urandom_range(0, 10)), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
